hyperbus_arbiter: RTL and testbench



---
 rtl/hyperbus_arbiter_if.sv | 62 ++++++
 rtl/hyperbus_arbiter.sv | 133 +++++++++++++
 tb/tb_hyperbus_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperbus_arbiter_if.sv
// rtl/hyperbus_arbiter_if.sv - requester and core-side signal bundle for hyperbus_arbiter
//
// Purpose: groups the two requester ports and the HyperBus core request port.
//   slave  modport: the arbiter's view (requester inputs / core responses in,
//                   requester responses / core requests out).
//   master modport: the environment's view (requesters plus core), mirrored.
// Port summary:
//   mN_adr_i/mN_dat_i/mN_rrq/mN_wrq : requester N address, write data, read/write request
//   mN_ready/mN_valid/mN_dat_o      : accept pulse, read data valid, read data
//   mN_done/mN_err                  : completion pulse, watchdog abort pulse
//   hbus_adr_o/hbus_dat_o           : latched address / write data to core
//   hbus_rrq/hbus_wrq               : read / write request to core
//   hbus_dat_i/hbus_ready/hbus_valid/hbus_busy : core read data, accept, data valid, busy
interface hyperbus_arbiter_if #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16
);
    logic [HBUS_ADDR_WIDTH-1:0] m0_adr_i;
    logic [HBUS_ADDR_WIDTH-1:0] m1_adr_i;
    logic [HBUS_DATA_WIDTH-1:0] m0_dat_i;
    logic [HBUS_DATA_WIDTH-1:0] m1_dat_i;
    logic                       m0_rrq;
    logic                       m0_wrq;
    logic                       m1_rrq;
    logic                       m1_wrq;
    logic                       m0_ready;
    logic                       m1_ready;
    logic                       m0_valid;
    logic                       m1_valid;
    logic [HBUS_DATA_WIDTH-1:0] m0_dat_o;
    logic [HBUS_DATA_WIDTH-1:0] m1_dat_o;
    logic                       m0_done;
    logic                       m1_done;
    logic                       m0_err;
    logic                       m1_err;
    logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o;
    logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o;
    logic                       hbus_rrq;
    logic                       hbus_wrq;
    logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i;
    logic                       hbus_ready;
    logic                       hbus_valid;
    logic                       hbus_busy;

    modport slave (
        input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i,
        input  m0_rrq, m0_wrq, m1_rrq, m1_wrq,
        output m0_ready, m1_ready, m0_valid, m1_valid, m0_dat_o, m1_dat_o,
        output m0_done, m1_done, m0_err, m1_err,
        output hbus_adr_o, hbus_dat_o, hbus_rrq, hbus_wrq,
        input  hbus_dat_i, hbus_ready, hbus_valid, hbus_busy
    );

    modport master (
        output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i,
        output m0_rrq, m0_wrq, m1_rrq, m1_wrq,
        input  m0_ready, m1_ready, m0_valid, m1_valid, m0_dat_o, m1_dat_o,
        input  m0_done, m1_done, m0_err, m1_err,
        input  hbus_adr_o, hbus_dat_o, hbus_rrq, hbus_wrq,
        output hbus_dat_i, hbus_ready, hbus_valid, hbus_busy
    );
endinterface

// File: rtl/hyperbus_arbiter.sv
// rtl/hyperbus_arbiter.sv - two-requester round-robin arbiter for a HyperBus core request port
//
// Purpose: latches the winning request, drives the core request lines, routes
//   accept / read data / completion back to the winner, and releases the bus
//   once the core reports idle.
// Ports:
//   wb_clk : sole clock, rising edge
//   wb_rst : asynchronous active-high reset
//   bus    : hyperbus_arbiter_if.slave (requester ports and core request port)
// Optional feature: define HYPERBUS_ARB_TIMEOUT_EN to enable the ISSUE/WAIT
//   watchdog (TIMEOUT_CYCLES); without it mN_err is constant 0.
module hyperbus_arbiter #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    hyperbus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       grant_q;       // 0: m0 owns the bus, 1: m1
    logic                       last_grant_q;  // reset to 1 so m0 wins the first tie
    logic                       op_wr_q;
    logic [HBUS_ADDR_WIDTH-1:0] adr_q;
    logic [HBUS_DATA_WIDTH-1:0] dat_q;
    logic [1:0]                 done_q;
    logic [1:0]                 err_q;

    logic req0, req1, pick1, start, complete, accept;
    logic timeout;

    always_comb begin
        req0     = bus.m0_rrq | bus.m0_wrq;
        req1     = bus.m1_rrq | bus.m1_wrq;
        // m1 wins when it is alone, or on a tie when m0 was served last.
        pick1    = req1 & (~req0 | ~last_grant_q);
        start    = (state_q == IDLE) & ~bus.hbus_busy & (req0 | req1);
        complete = (state_q == WAIT) & ~bus.hbus_busy;
    end

`ifdef HYPERBUS_ARB_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            tmr_q <= '0;
        end else if (start) begin
            tmr_q <= '0;
        end else if (state_q != IDLE) begin
            tmr_q <= tmr_q + 1'b1;
        end
    end

    // A completion seen in the last cycle still counts as a normal finish.
    assign timeout = (state_q != IDLE) & (tmr_q == TMR_LAST) & ~complete;
`else
    assign timeout = 1'b0;
`endif

    // Abort takes priority over a late accept so the requester sees only err.
    assign accept = (state_q == ISSUE) & bus.hbus_ready & ~timeout;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (timeout) state_d = IDLE;
                     else if (accept) state_d = WAIT;
            WAIT:    if (complete || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_wr_q      <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
        end else begin
            if (start) begin
                grant_q <= pick1;
                // Write wins when a requester raises rrq and wrq together.
                op_wr_q <= pick1 ? bus.m1_wrq   : bus.m0_wrq;
                adr_q   <= pick1 ? bus.m1_adr_i : bus.m0_adr_i;
                dat_q   <= pick1 ? bus.m1_dat_i : bus.m0_dat_i;
            end
            if (complete || timeout) begin
                last_grant_q <= grant_q;
            end
            done_q <= {complete & grant_q, complete & ~grant_q};
            err_q  <= {timeout & grant_q, timeout & ~grant_q};
        end
    end

    always_comb begin
        bus.hbus_rrq   = (state_q == ISSUE) & ~op_wr_q;
        bus.hbus_wrq   = (state_q == ISSUE) & op_wr_q;
        bus.hbus_adr_o = adr_q;
        bus.hbus_dat_o = dat_q;
        bus.m0_ready   = accept & ~grant_q;
        bus.m1_ready   = accept & grant_q;
        bus.m0_valid   = (state_q == WAIT) & bus.hbus_valid & ~grant_q;
        bus.m1_valid   = (state_q == WAIT) & bus.hbus_valid & grant_q;
        bus.m0_dat_o   = bus.hbus_dat_i;
        bus.m1_dat_o   = bus.hbus_dat_i;
        bus.m0_done    = done_q[0];
        bus.m1_done    = done_q[1];
        bus.m0_err     = err_q[0];
        bus.m1_err     = err_q[1];
    end
endmodule

// File: tb/tb_hyperbus_arbiter.sv
// tb/tb_hyperbus_arbiter.sv - scoreboard testbench for hyperbus_arbiter
`timescale 1ns/1ps
module tb_hyperbus_arbiter;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int TO = 16;

    logic wb_clk = 1'b0;
    logic wb_rst = 1'b1;

    hyperbus_arbiter_if #(.HBUS_ADDR_WIDTH(AW), .HBUS_DATA_WIDTH(DW)) bus ();

    hyperbus_arbiter #(
        .HBUS_ADDR_WIDTH(AW),
        .HBUS_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk(wb_clk),
        .wb_rst(wb_rst),
        .bus   (bus)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        int          who;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic        wr;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic        rrq;
        logic        wrq;
        int          cyc;
    } iss_t;

    typedef struct {
        int          who;
        logic [DW-1:0] data;
    } val_t;

    exp_t exp_q[$];
    iss_t iss_q[$];
    val_t val_q[$];
    int   rdy_q[$];
    int   done_q[$];
    int   done_cyc_q[$];
    int   err_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   rq_cnt = 0;
    logic prev_req = 1'b0;
    bit   drop0 = 1'b0;
    bit   drop1 = 1'b0;

    // core model configuration
    bit            core_en     = 1'b1;
    bit            core_active = 1'b0;
    bit            busy_force  = 1'b0;
    bit            core_is_rd  = 1'b0;
    int            core_t      = 0;
    int            ready_dly   = 1;
    int            valid_dly   = 2;
    int            busy_dly    = 3;
    logic [DW-1:0] core_rdata  = '0;

    // Monitor: records what the DUT produces, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge wb_clk);
            cyc++;
            if (bus.hbus_rrq | bus.hbus_wrq) begin
                rq_cnt++;
                if (!prev_req)
                    iss_q.push_back('{bus.hbus_adr_o, bus.hbus_dat_o, bus.hbus_rrq, bus.hbus_wrq, cyc});
            end
            prev_req = bus.hbus_rrq | bus.hbus_wrq;
            if (bus.m0_ready) begin rdy_q.push_back(0); drop0 = 1'b1; end
            if (bus.m1_ready) begin rdy_q.push_back(1); drop1 = 1'b1; end
            if (bus.m0_valid) val_q.push_back('{0, bus.m0_dat_o});
            if (bus.m1_valid) val_q.push_back('{1, bus.m1_dat_o});
            if (bus.m0_done) begin done_q.push_back(0); done_cyc_q.push_back(cyc); end
            if (bus.m1_done) begin done_q.push_back(1); done_cyc_q.push_back(cyc); end
            if (bus.m0_err) err_q.push_back(0);
            if (bus.m1_err) err_q.push_back(1);
        end
    end

    // Core model and requester auto-release, driven 1ns after the rising edge.
    initial begin
        bus.hbus_ready = 1'b0;
        bus.hbus_valid = 1'b0;
        bus.hbus_busy  = 1'b0;
        bus.hbus_dat_i = '0;
        forever begin
            @(posedge wb_clk);
            #1;
            if (drop0) begin bus.m0_rrq = 1'b0; bus.m0_wrq = 1'b0; drop0 = 1'b0; end
            if (drop1) begin bus.m1_rrq = 1'b0; bus.m1_wrq = 1'b0; drop1 = 1'b0; end
            if (core_en && !core_active && (bus.hbus_rrq | bus.hbus_wrq)) begin
                core_active = 1'b1;
                core_t      = 0;
                core_is_rd  = bus.hbus_rrq;
            end
            if (core_active) begin
                bus.hbus_ready = (core_t == ready_dly);
                bus.hbus_valid = core_is_rd && (core_t == valid_dly);
                bus.hbus_dat_i = (core_t == valid_dly) ? core_rdata : '0;
                bus.hbus_busy  = (core_t >= ready_dly) && (core_t < busy_dly);
                if (core_t >= busy_dly) core_active = 1'b0;
                core_t++;
            end else begin
                bus.hbus_ready = 1'b0;
                bus.hbus_valid = 1'b0;
                bus.hbus_busy  = busy_force;
                bus.hbus_dat_i = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge wb_clk);
            #2;
        end
    endtask

    task automatic clear_obs();
        exp_q.delete(); iss_q.delete(); val_q.delete(); rdy_q.delete();
        done_q.delete(); done_cyc_q.delete(); err_q.delete();
        rq_cnt = 0;
    endtask

    // kind 0: issues, 1: ready pulses, 2: done pulses
    task automatic wait_count(input int kind, input int n, input int budget, output bit ok);
        int sz;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            sz = (kind == 0) ? iss_q.size() : (kind == 1) ? rdy_q.size() : done_q.size();
            if (sz >= n) begin ok = 1'b1; break; end
            tick(1);
        end
    endtask

    task automatic test_reset();
        wb_rst = 1'b1;
        tick(2);
        checks++;
        if ({bus.hbus_rrq, bus.hbus_wrq} !== 2'b00) begin
            errors++; $display("FAIL reset_req: got %b want 00", {bus.hbus_rrq, bus.hbus_wrq});
        end
        checks++;
        if (bus.hbus_adr_o !== '0 || bus.hbus_dat_o !== '0) begin
            errors++; $display("FAIL reset_adr_dat: got %h/%h want 0/0", bus.hbus_adr_o, bus.hbus_dat_o);
        end
        checks++;
        if ({bus.m0_ready, bus.m0_valid, bus.m0_done, bus.m0_err,
             bus.m1_ready, bus.m1_valid, bus.m1_done, bus.m1_err} !== 8'h00) begin
            errors++; $display("FAIL reset_resp: got %b want 00000000",
                {bus.m0_ready, bus.m0_valid, bus.m0_done, bus.m0_err,
                 bus.m1_ready, bus.m1_valid, bus.m1_done, bus.m1_err});
        end
        wb_rst = 1'b0;
        tick(1);
    endtask

    task automatic test_single_read();
        exp_t e;
        iss_t i;
        int   t0;
        bit   ok;
        clear_obs();
        ready_dly = 2; valid_dly = 4; busy_dly = 6; core_rdata = 16'hBEEF;
        exp_q.push_back('{0, 32'h0000_1000, 16'h1234, 1'b0, 16'hBEEF});
        bus.m0_adr_i = 32'h0000_1000; bus.m0_dat_i = 16'h1234; bus.m0_rrq = 1'b1;
        t0 = cyc;
        wait_count(2, 1, 40, ok);
        tick(4);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL rd_done_wait: got timeout want done"); end
        checks++;
        if (iss_q.size() != 1) begin
            errors++; $display("FAIL rd_issue_count: got %0d want 1", iss_q.size());
        end else begin
            i = iss_q[0];
            checks++;
            if (i.adr !== e.adr || {i.rrq, i.wrq} !== {~e.wr, e.wr}) begin
                errors++; $display("FAIL rd_issue: got %h rrq%b wrq%b want %h rrq%b wrq%b",
                    i.adr, i.rrq, i.wrq, e.adr, ~e.wr, e.wr);
            end
            checks++;
            if (i.cyc != t0 + 2) begin
                errors++; $display("FAIL rd_latency: got cycle %0d want %0d", i.cyc, t0 + 2);
            end
        end
        checks++;
        if (rdy_q.size() != 1 || rdy_q[0] != e.who) begin
            errors++; $display("FAIL rd_ready: got %0d pulses want 1 for m%0d", rdy_q.size(), e.who);
        end
        checks++;
        if (val_q.size() != 1 || val_q[0].who != e.who || val_q[0].data !== e.rdata) begin
            errors++; $display("FAIL rd_valid: got %0d beats want 1 beat m%0d data %h", val_q.size(), e.who, e.rdata);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != e.who || err_q.size() != 0) begin
            errors++; $display("FAIL rd_done: got %0d done %0d err want 1 done m%0d 0 err",
                done_q.size(), err_q.size(), e.who);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit   ok;
        wb_rst = 1'b1; tick(1); wb_rst = 1'b0; tick(1);
        clear_obs();
        ready_dly = 1; valid_dly = 2; busy_dly = 3;
        for (int p = 0; p < 2; p++) begin
            exp_q.push_back('{0, 32'h0000_00A0 + p * 4, 16'h1111 + 16'(p), 1'b1, 16'h0});
            exp_q.push_back('{1, 32'h0000_00B0 + p * 4, 16'h2222 + 16'(p), 1'b1, 16'h0});
            bus.m0_adr_i = 32'h0000_00A0 + p * 4; bus.m0_dat_i = 16'h1111 + 16'(p); bus.m0_wrq = 1'b1;
            bus.m1_adr_i = 32'h0000_00B0 + p * 4; bus.m1_dat_i = 16'h2222 + 16'(p); bus.m1_wrq = 1'b1;
            wait_count(2, 2 * (p + 1), 60, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rr_done_wait pair %0d: got timeout want done", p); end
        end
        tick(3);
        checks++;
        if (iss_q.size() != 4 || rdy_q.size() != 4 || done_q.size() != 4) begin
            errors++; $display("FAIL rr_counts: got iss %0d rdy %0d done %0d want 4 4 4",
                iss_q.size(), rdy_q.size(), done_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                e = exp_q.pop_front();
                checks++;
                if (iss_q[k].adr !== e.adr || iss_q[k].dat !== e.dat || iss_q[k].wrq !== 1'b1 ||
                    iss_q[k].rrq !== 1'b0 || rdy_q[k] != e.who || done_q[k] != e.who) begin
                    errors++; $display("FAIL rr_txn%0d: got adr %h dat %h rdy m%0d done m%0d want adr %h dat %h m%0d",
                        k, iss_q[k].adr, iss_q[k].dat, rdy_q[k], done_q[k], e.adr, e.dat, e.who);
                end
            end
            checks++;
            if (iss_q[1].cyc != done_cyc_q[0] + 1) begin
                errors++; $display("FAIL rr_gap: got issue cycle %0d want %0d", iss_q[1].cyc, done_cyc_q[0] + 1);
            end
        end
    endtask

    task automatic test_both_ops();
        bit ok;
        clear_obs();
        ready_dly = 0; valid_dly = 1; busy_dly = 2;
        bus.m1_adr_i = 32'h0000_0020; bus.m1_dat_i = 16'h55AA;
        bus.m1_rrq = 1'b1; bus.m1_wrq = 1'b1;
        wait_count(2, 1, 30, ok);
        tick(2);
        checks++;
        if (!ok || iss_q.size() != 1) begin
            errors++; $display("FAIL both_issue: got %0d issues want 1", iss_q.size());
        end else begin
            checks++;
            if (iss_q[0].wrq !== 1'b1 || iss_q[0].rrq !== 1'b0 || iss_q[0].dat !== 16'h55AA ||
                iss_q[0].adr !== 32'h0000_0020) begin
                errors++; $display("FAIL both_op: got wrq%b rrq%b dat %h adr %h want wrq1 rrq0 dat 55aa adr 00000020",
                    iss_q[0].wrq, iss_q[0].rrq, iss_q[0].dat, iss_q[0].adr);
            end
        end
        checks++;
        if (rdy_q.size() != 1 || rdy_q[0] != 1 || done_q.size() != 1 || done_q[0] != 1 || val_q.size() != 0) begin
            errors++; $display("FAIL both_resp: got rdy %0d done %0d val %0d want 1 1 0 for m1",
                rdy_q.size(), done_q.size(), val_q.size());
        end
    endtask

    task automatic test_busy_hold();
        int t0;
        bit ok;
        clear_obs();
        ready_dly = 1; valid_dly = 2; busy_dly = 3; core_rdata = 16'h0A0A;
        busy_force = 1'b1; bus.hbus_busy = 1'b1;
        bus.m0_adr_i = 32'h0000_0300; bus.m0_rrq = 1'b1;
        bus.m1_adr_i = 32'h0000_0900; bus.m1_wrq = 1'b1;
        tick(2);
        bus.m1_wrq = 1'b0;
        tick(3);
        checks++;
        if (iss_q.size() != 0) begin
            errors++; $display("FAIL busy_hold: got %0d issues want 0", iss_q.size());
        end
        busy_force = 1'b0; bus.hbus_busy = 1'b0;
        t0 = cyc;
        wait_count(2, 1, 30, ok);
        tick(3);
        checks++;
        if (!ok || iss_q.size() != 1) begin
            errors++; $display("FAIL busy_release: got %0d issues want 1", iss_q.size());
        end else begin
            checks++;
            if (iss_q[0].cyc != t0 + 2 || iss_q[0].rrq !== 1'b1 || iss_q[0].adr !== 32'h0000_0300) begin
                errors++; $display("FAIL busy_issue: got cycle %0d rrq %b adr %h want cycle %0d rrq 1 adr 00000300",
                    iss_q[0].cyc, iss_q[0].rrq, iss_q[0].adr, t0 + 2);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 0 || val_q.size() != 1 || val_q[0].data !== 16'h0A0A) begin
            errors++; $display("FAIL busy_resp: got done %0d val %0d want 1 done 1 val 0a0a for m0",
                done_q.size(), val_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_obs();
        ready_dly = 1; valid_dly = 20; busy_dly = 30; core_rdata = 16'h4321;
        bus.m0_adr_i = 32'h4444_0000; bus.m0_dat_i = 16'h0077; bus.m0_rrq = 1'b1;
        wait_count(1, 1, 20, ok);
        tick(2);
        checks++;
        if (!ok || bus.hbus_adr_o !== 32'h4444_0000) begin
            errors++; $display("FAIL mid_setup: got adr %h want 44440000", bus.hbus_adr_o);
        end
        #1;
        wb_rst = 1'b1;
        #1;
        checks++;
        if (bus.hbus_adr_o !== '0 || {bus.hbus_rrq, bus.hbus_wrq, bus.m0_ready, bus.m0_valid, bus.m0_done} !== 5'b0) begin
            errors++; $display("FAIL mid_async: got adr %h flags %b want 0 00000", bus.hbus_adr_o,
                {bus.hbus_rrq, bus.hbus_wrq, bus.m0_ready, bus.m0_valid, bus.m0_done});
        end
        core_active = 1'b0;
        bus.hbus_busy = 1'b0; bus.hbus_ready = 1'b0; bus.hbus_valid = 1'b0;
        bus.m0_rrq = 1'b0;
        tick(2);
        wb_rst = 1'b0;
        tick(3);
        checks++;
        if (done_q.size() != 0 || err_q.size() != 0) begin
            errors++; $display("FAIL mid_nodone: got done %0d err %0d want 0 0", done_q.size(), err_q.size());
        end
        clear_obs();
        ready_dly = 1; valid_dly = 2; busy_dly = 3;
        bus.m0_adr_i = 32'h0000_5000; bus.m0_rrq = 1'b1;
        bus.m1_adr_i = 32'h0000_6000; bus.m1_rrq = 1'b1;
        wait_count(2, 2, 60, ok);
        checks++;
        if (!ok || iss_q.size() < 1 || iss_q[0].adr !== 32'h0000_5000 || done_q[0] != 0) begin
            errors++; $display("FAIL mid_tie: got %0d issues first adr %h want m0 adr 00005000",
                iss_q.size(), (iss_q.size() > 0) ? iss_q[0].adr : 32'h0);
        end
    endtask

`ifdef HYPERBUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        clear_obs();
        core_en = 1'b0;
        bus.m0_adr_i = 32'h0000_0700; bus.m0_rrq = 1'b1;
        wait_count(0, 1, 10, ok);
        bus.m0_rrq = 1'b0;
        tick(TO + 5);
        checks++;
        if (!ok || rq_cnt != TO) begin
            errors++; $display("FAIL to_req_cycles: got %0d want %0d", rq_cnt, TO);
        end
        checks++;
        if (err_q.size() != 1 || err_q[0] != 0 || done_q.size() != 0 || rdy_q.size() != 0) begin
            errors++; $display("FAIL to_err: got err %0d done %0d rdy %0d want 1 0 0",
                err_q.size(), done_q.size(), rdy_q.size());
        end
        core_en = 1'b1;
    endtask
`endif

    initial begin
        bus.m0_adr_i = '0; bus.m0_dat_i = '0; bus.m0_rrq = 1'b0; bus.m0_wrq = 1'b0;
        bus.m1_adr_i = '0; bus.m1_dat_i = '0; bus.m1_rrq = 1'b0; bus.m1_wrq = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_both_ops();
        test_busy_hold();
        test_reset_mid();
`ifdef HYPERBUS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
